// File: rtl/capture_buffer.sv
// capture_buffer: writes a stream of signed ADC samples into a circular RAM, waits
// for a level/edge (or timed-out auto) trigger while keeping a programmable
// pre-trigger history, then unrolls the RAM in time order into a parallel frame.
module capture_buffer #(
  parameter int DEPTH        = 256,
  parameter int WIDTH        = 12,
  parameter int AUTO_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] adc_data_i,
  input  logic                    adc_valid_i,
  input  logic                    arm_i,
  input  logic signed [WIDTH-1:0] trig_level_i,
  input  logic                    trig_edge_i,
  input  logic                    trig_auto_i,
  input  logic [7:0]              pretrig_i,
  input  logic                    frame_ack_i,
  output logic signed [WIDTH-1:0] data_out_o [0:DEPTH-1],
  output logic                    frame_valid_o,
  output logic                    busy_o,
  output logic                    trig_forced_o
);

  localparam int AW  = $clog2(DEPTH);
  // One counter serves FILL, ARMED (auto timeout), POST and UNROLL, so it must
  // hold both AUTO_TIMEOUT and DEPTH.
  localparam int CW1 = $clog2(AUTO_TIMEOUT + 1);
  localparam int CW2 = $clog2(DEPTH + 1);
  localparam int CW  = (CW1 > CW2) ? CW1 : CW2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_ARMED  = 3'd2,
    S_POST   = 3'd3,
    S_UNROLL = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [AW-1:0]           pre_q, pre_d;
  logic [AW-1:0]           trig_ptr_q, trig_ptr_d;
  logic signed [WIDTH-1:0] prev_q, prev_d;
  logic                    seeded_q, seeded_d;
  logic                    forced_q, forced_d;
  logic                    frame_valid_q;
  logic                    busy_q;

  logic signed [WIDTH-1:0] mem_q      [0:DEPTH-1];
  logic signed [WIDTH-1:0] data_out_q [0:DEPTH-1];

  logic                    wr_en_s;
  logic                    rise_s;
  logic                    fall_s;
  logic                    real_hit_s;
  logic                    auto_hit_s;
  logic [AW-1:0]           post_s;
  logic [AW-1:0]           rd_base_s;
  logic [AW-1:0]           rd_addr_s;
  logic                    unroll_wr_s;

  // Trigger detection, RAM write enable and unroll addressing.
  always_comb begin
    rise_s = (prev_q < trig_level_i) && (adc_data_i >= trig_level_i);
    fall_s = (prev_q > trig_level_i) && (adc_data_i <= trig_level_i);
    // seeded_q is clear only for the very first sample after an arm with no history.
    if (trig_edge_i) begin
      real_hit_s = seeded_q && fall_s;
    end else begin
      real_hit_s = seeded_q && rise_s;
    end
    auto_hit_s  = trig_auto_i && (cnt_q >= CW'(AUTO_TIMEOUT - 1));
    post_s      = AW'(DEPTH - 1) - pre_q;
    rd_base_s   = trig_ptr_q - pre_q;
    rd_addr_s   = rd_base_s + cnt_q[AW-1:0];
    wr_en_s     = adc_valid_i &&
                  ((state_q == S_FILL) || (state_q == S_ARMED) || (state_q == S_POST));
    unroll_wr_s = (state_q == S_UNROLL) && (cnt_q < CW'(DEPTH));
  end

  // Next-state and datapath control for the acquisition sequence.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    pre_d      = pre_q;
    trig_ptr_d = trig_ptr_q;
    prev_d     = prev_q;
    seeded_d   = seeded_q;
    forced_d   = forced_q;

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      prev_d   = adc_data_i;
      seeded_d = 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (arm_i) begin
          pre_d    = pretrig_i[AW-1:0];
          wr_ptr_d = '0;
          cnt_d    = '0;
          seeded_d = 1'b0;
          if (pretrig_i[AW-1:0] == '0) begin
            state_d = S_ARMED;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (adc_valid_i) begin
          if ((cnt_q + CW'(1)) == CW'(pre_q)) begin
            state_d = S_ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_ARMED: begin
        if (adc_valid_i) begin
          if (real_hit_s || auto_hit_s) begin
            // A genuine crossing on the timeout sample takes precedence.
            trig_ptr_d = wr_ptr_q;
            forced_d   = ~real_hit_s;
            cnt_d      = '0;
            if (post_s == '0) begin
              state_d = S_UNROLL;
            end else begin
              state_d = S_POST;
            end
          end else if (cnt_q < CW'(AUTO_TIMEOUT)) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_POST: begin
        if (adc_valid_i) begin
          if ((cnt_q + CW'(1)) == CW'(post_s)) begin
            state_d = S_UNROLL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_UNROLL: begin
        // DEPTH copy cycles plus one closing cycle before the frame is presented.
        if (cnt_q == CW'(DEPTH)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (frame_ack_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, pointers, counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      pre_q         <= '0;
      trig_ptr_q    <= '0;
      prev_q        <= '0;
      seeded_q      <= 1'b0;
      forced_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      cnt_q         <= cnt_d;
      pre_q         <= pre_d;
      trig_ptr_q    <= trig_ptr_d;
      prev_q        <= prev_d;
      seeded_q      <= seeded_d;
      forced_q      <= forced_d;
      frame_valid_q <= (state_d == S_DONE);
      busy_q        <= (state_d == S_FILL) || (state_d == S_ARMED) ||
                       (state_d == S_POST) || (state_d == S_UNROLL);
    end
  end

  // Circular sample RAM; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= adc_data_i;
    end
  end

  // Frame array: one entry copied per UNROLL cycle, otherwise holds the last frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_out_q[i] <= '0;
      end
    end else if (unroll_wr_s) begin
      data_out_q[cnt_q[AW-1:0]] <= mem_q[rd_addr_s];
    end
  end

  assign data_out_o    = data_out_q;
  assign frame_valid_o = frame_valid_q;
  assign busy_o        = busy_q;
  assign trig_forced_o = forced_q;

endmodule

// File: tb/tb_capture_buffer.sv
// Bench for capture_buffer: directed vector table, randomized captures against a
// sample-history reference model, and reset-abort sequences.
module tb_capture_buffer;

  localparam int DEPTH        = 256;
  localparam int WIDTH        = 12;
  localparam int AUTO_TIMEOUT = 1024;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic signed [WIDTH-1:0] adc_data_i;
  logic                    adc_valid_i;
  logic                    arm_i;
  logic signed [WIDTH-1:0] trig_level_i;
  logic                    trig_edge_i;
  logic                    trig_auto_i;
  logic [7:0]              pretrig_i;
  logic                    frame_ack_i;
  logic signed [WIDTH-1:0] data_out_o [0:DEPTH-1];
  logic                    frame_valid_o;
  logic                    busy_o;
  logic                    trig_forced_o;

  capture_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AUTO_TIMEOUT(AUTO_TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .adc_data_i   (adc_data_i),
    .adc_valid_i  (adc_valid_i),
    .arm_i        (arm_i),
    .trig_level_i (trig_level_i),
    .trig_edge_i  (trig_edge_i),
    .trig_auto_i  (trig_auto_i),
    .pretrig_i    (pretrig_i),
    .frame_ack_i  (frame_ack_i),
    .data_out_o   (data_out_o),
    .frame_valid_o(frame_valid_o),
    .busy_o       (busy_o),
    .trig_forced_o(trig_forced_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: every sample accepted since arm, in time order.
  int hist[$];
  int trig_k;
  bit forced_exp;
  int trig_cyc;
  int exp_frame[DEPTH];

  typedef struct {
    int pre;
    int lvl;
    bit edg;
    bit aut;
    int mode;    // 0 ramp up, 1 ramp down by 2, 2 constant 0, 3 random
    int gap;     // 0 dense, 1 alternate, 2 random valid
    int start;
    bit forced;
    int i0; int v0;
    int i1; int v1;
    int i2; int v2;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int gen(input int mode, input int n, input int start);
    case (mode)
      0:       return start + n;
      1:       return start - 2 * n;
      2:       return 0;
      default: return int'($urandom_range(0, 127)) - 64;
    endcase
  endfunction

  function automatic int nonzero_cnt();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (data_out_o[i] !== '0) c++;
    return c;
  endfunction

  // Arm, then stream samples while the model decides where the trigger lands.
  // limit > 0 stops after that many accepted samples (used to abort mid-capture).
  task automatic feed(input vec_t v, input int limit);
    int  n = 0;
    int  guard = 0;
    int  x;
    int  k;
    bit  val;
    bit  real_hit;
    pretrig_i    = 8'(v.pre);
    trig_level_i = WIDTH'(v.lvl);
    trig_edge_i  = v.edg;
    trig_auto_i  = v.aut;
    hist.delete();
    trig_k     = -1;
    forced_exp = 1'b0;
    trig_cyc   = 0;
    arm_i       = 1'b1;
    adc_valid_i = 1'b1;
    adc_data_i  = 12'sd1000;   // arriving in IDLE: must be dropped
    tick();
    arm_i     = 1'b0;
    pretrig_i = 8'($urandom);  // pre was latched on arm
    chk("busy_after_arm", busy_o, 1);
    forever begin
      if (limit > 0 && hist.size() >= limit) break;
      if (trig_k >= 0 && hist.size() == trig_k + DEPTH - v.pre) break;
      if (guard >= 8000) break;
      guard++;
      case (v.gap)
        0:       val = 1'b1;
        1:       val = (guard % 2) == 1;
        default: val = 1'($urandom_range(0, 1));
      endcase
      frame_ack_i = (guard == 3);
      adc_valid_i = val;
      if (val) begin
        x = gen(v.mode, n, v.start);
        n++;
        adc_data_i = WIDTH'(x);
        hist.push_back(x);
        k = hist.size() - 1;
        if (trig_k < 0 && k >= v.pre) begin
          real_hit = 1'b0;
          if (k >= 1) begin
            if (v.edg) real_hit = (hist[k-1] > v.lvl) && (x <= v.lvl);
            else       real_hit = (hist[k-1] < v.lvl) && (x >= v.lvl);
          end
          if (real_hit || (v.aut && (k - v.pre + 1) >= AUTO_TIMEOUT)) begin
            trig_k     = k;
            forced_exp = !real_hit;
            trig_cyc   = cyc + 1;
          end
        end
      end else begin
        adc_data_i = WIDTH'($urandom);
      end
      tick();
    end
    adc_valid_i = 1'b0;
    frame_ack_i = 1'b0;
  endtask

  // Wait for the frame, compare it with the model, then exercise DONE handshakes.
  task automatic finish(input vec_t v, input bit directed, input bit dense);
    int guard = 0;
    int mism  = 0;
    chk("trigger_found", trig_k >= 0, 1);
    if (trig_k < 0) return;
    for (int i = 0; i < DEPTH; i++) exp_frame[i] = hist[trig_k - v.pre + i];
    adc_valid_i = 1'b1;
    while (frame_valid_o !== 1'b1 && guard < 1000) begin
      guard++;
      arm_i      = (guard == 5);
      adc_data_i = WIDTH'($urandom);
      tick();
    end
    arm_i       = 1'b0;
    adc_valid_i = 1'b0;
    chk("frame_valid", frame_valid_o, 1);
    if (dense) chk("latency", cyc - trig_cyc, (DEPTH - 1 - v.pre) + DEPTH + 1);
    chk("busy_done", busy_o, 0);
    chk("trig_forced", trig_forced_o, directed ? v.forced : forced_exp);
    for (int i = 0; i < DEPTH; i++) if (data_out_o[i] !== WIDTH'(exp_frame[i])) mism++;
    chk("frame_mismatches", mism, 0);
    if (directed) begin
      chk($sformatf("data_out[%0d]", v.i0), data_out_o[v.i0], v.v0);
      chk($sformatf("data_out[%0d]", v.i1), data_out_o[v.i1], v.v1);
      chk($sformatf("data_out[%0d]", v.i2), data_out_o[v.i2], v.v2);
    end
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    chk("arm_in_done", frame_valid_o, 1);
    frame_ack_i = 1'b1;
    arm_i       = 1'b1;  // same cycle as ack: still in DONE, so ignored
    tick();
    frame_ack_i = 1'b0;
    arm_i       = 1'b0;
    chk("fv_after_ack", frame_valid_o, 0);
    chk("arm_with_ack", busy_o, 0);
    chk("frame_hold", data_out_o[DEPTH-1], exp_frame[DEPTH-1]);
  endtask

  task automatic reset_pulse_check(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_fv"}, frame_valid_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_forced"}, trig_forced_o, 0);
    chk({tag, "_data_zero"}, nonzero_cnt(), 0);
    @(negedge clk) rst = 1'b0;
    tick();
  endtask

  initial begin
    vec_t r;
    adc_data_i   = '0;
    adc_valid_i  = 1'b0;
    arm_i        = 1'b0;
    trig_level_i = '0;
    trig_edge_i  = 1'b0;
    trig_auto_i  = 1'b0;
    pretrig_i    = 8'd0;
    frame_ack_i  = 1'b0;

    //        pre  lvl   edg  aut  mode gap start  forced  i0 v0     i1 v1    i2  v2
    vecs[0] = '{16,  100, 1'b0, 1'b0, 0, 0, -200,  1'b0,   0, 84,    16, 100,  255, 339};
    vecs[1] = '{0,   0,   1'b1, 1'b0, 1, 0, 5,     1'b0,   0, -1,    1, -3,    255, -511};
    vecs[2] = '{8,   100, 1'b0, 1'b1, 2, 0, 0,     1'b1,   0, 0,     8, 0,     255, 0};
    vecs[3] = '{16,  100, 1'b0, 1'b0, 0, 1, -200,  1'b0,   0, 84,    16, 100,  255, 339};
    vecs[4] = '{255, 0,   1'b0, 1'b0, 0, 0, -300,  1'b0,   0, -255,  128, -127, 255, 0};
    vecs[5] = '{4,   1000, 1'b0, 1'b0, 0, 0, -2000, 1'b0,  0, 996,   4, 1000,  255, 1251};

    repeat (3) tick();
    chk("reset_fv", frame_valid_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_forced", trig_forced_o, 0);
    chk("reset_data_zero", nonzero_cnt(), 0);
    @(negedge clk) rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      feed(vecs[i], 0);
      finish(vecs[i], 1'b1, vecs[i].gap == 0);
    end

    for (int i = 0; i < 6; i++) begin
      r       = vecs[0];
      r.pre   = int'($urandom_range(0, 255));
      r.lvl   = int'($urandom_range(0, 80)) - 40;
      r.edg   = 1'($urandom_range(0, 1));
      r.aut   = 1'($urandom_range(0, 1));
      r.mode  = 3;
      r.gap   = (i % 2 == 0) ? 0 : 2;
      feed(r, 0);
      finish(r, 1'b0, r.gap == 0);
    end

    // Abort during POST, then a clean re-arm.
    feed(vecs[0], 311);
    reset_pulse_check("rst_post");
    feed(vecs[0], 0);
    finish(vecs[0], 1'b1, 1'b1);

    // Abort mid-UNROLL of an auto-triggered frame, then a clean re-arm.
    feed(vecs[2], 0);
    repeat (100) tick();
    reset_pulse_check("rst_unroll");
    feed(vecs[1], 0);
    finish(vecs[1], 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
